// File: rtl/div_32bit_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_SPECIAL_BYPASS_EN to finish div-by-zero and signed overflow in one cycle.
module div_32bit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] resq_q, resq_d;
  logic [WIDTH-1:0] resr_q, resr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic             a_neg, b_neg;
  logic             is_dz, is_ov;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic             unused_bit;
  logic [WIDTH-1:0] qfix, rfix;
  logic [WIDTH-1:0] qres, rres;

  assign a_neg = i_signed & i_op_a[WIDTH-1];
  assign b_neg = i_signed & i_op_b[WIDTH-1];
  assign a_mag = a_neg ? (~i_op_a + ONE) : i_op_a;
  assign b_mag = b_neg ? (~i_op_b + ONE) : i_op_b;
  assign is_dz = (i_op_b == '0);
  assign is_ov = i_signed & (i_op_a == MIN) & (i_op_b == '1);

  // Partial remainder needs one extra bit once the divisor exceeds 2^(W-1).
  assign rem_sh    = {rem_q, quot_q[WIDTH-1]};
  assign trial     = {1'b0, rem_sh} + {2'b01, ~div_q} + (WIDTH+2)'(1);
  assign no_borrow = trial[WIDTH+1];
  assign unused_bit = trial[WIDTH];

  assign qfix = qneg_q ? (~quot_q + ONE) : quot_q;
  assign rfix = rneg_q ? (~rem_q + ONE) : rem_q;
  // Div-by-zero remainder falls out of the iterations (or bypass load) as a.
  assign qres = dz_q ? '1 : (ov_q ? MIN : qfix);
  assign rres = ov_q ? '0 : rfix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    div_d   = div_q;
    resq_d  = resq_q;
    resr_d  = resr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = is_dz;
          ov_d    = is_ov;
          div_d   = b_mag;
          rem_d   = '0;
          quot_d  = a_mag;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_SPECIAL_BYPASS_EN
          if (is_dz | is_ov) begin
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            rem_d   = i_op_a;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        quot_d = {quot_q[WIDTH-2:0], no_borrow};
        rem_d  = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
      end
      DONE: begin
        resq_d  = qres;
        resr_d  = rres;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      div_q   <= '0;
      resq_q  <= '0;
      resr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      div_q   <= div_d;
      resq_q  <= resq_d;
      resr_q  <= resr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign o_busy  = (state_q == CALC);
  assign o_valid = (state_q == DONE);
  assign o_quot  = o_valid ? qres : resq_q;
  assign o_rem   = o_valid ? rres : resr_q;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Directed bench for div_32bit_seq.
// Special-case latency follows DIV_SPECIAL_BYPASS_EN.
module tb_div_32bit_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_signed;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_quot;
  logic [31:0] o_rem;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DIV_SPECIAL_BYPASS_EN
  localparam int SLAT = 1;
`else
  localparam int SLAT = 33;
`endif

  div_32bit_seq #(.WIDTH(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_signed(i_signed),
    .i_op_a  (i_op_a),
    .i_op_b  (i_op_b),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_quot  (o_quot),
    .o_rem   (o_rem)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a,
                     input logic [31:0] b, input logic s,
                     input logic [31:0] eq, input logic [31:0] er,
                     input int elat, input int inj);
    int nv;
    int lat;
    logic busy1, vbusy;
    logic [31:0] gq, gr;
    nv = 0; lat = 0; busy1 = 1'b0; vbusy = 1'b1;
    gq = '0; gr = '0;
    i_op_a = a; i_op_b = b; i_signed = s; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_op_a = 32'hDEAD_BEEF;
    i_op_b = 32'h1;
    i_signed = ~s;
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      if (k == 1) busy1 = o_busy;
      if (inj != 0 && k == inj) begin
        i_op_a = 32'd9; i_op_b = 32'd3; i_start = 1'b1;
      end
      if (inj != 0 && k == inj + 1) i_start = 1'b0;
      if (o_valid) begin
        nv++;
        if (nv == 1) begin
          lat = k; gq = o_quot; gr = o_rem; vbusy = o_busy;
        end
      end
    end
    check({tag, " nvalid"}, 32'(nv), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " busy1"}, {31'b0, busy1}, {31'b0, elat > 1});
    check({tag, " busy@valid"}, {31'b0, vbusy}, 32'd0);
    check({tag, " quot"}, gq, eq);
    check({tag, " rem"}, gr, er);
    check({tag, " quot held"}, o_quot, eq);
    check({tag, " rem held"}, o_rem, er);
  endtask

  initial begin
    int nv;
    i_rst_n = 1'b0; i_start = 1'b0; i_signed = 1'b0;
    i_op_a = '0; i_op_b = '0;
    repeat (2) @(negedge i_clk);
    check("rst busy", {31'b0, o_busy}, 32'd0);
    check("rst valid", {31'b0, o_valid}, 32'd0);
    check("rst quot", o_quot, 32'd0);
    check("rst rem", o_rem, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run("u100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 0);
    run("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1,
        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
    run("s-100/7", 32'hFFFF_FF9C, 32'd7, 1'b1,
        32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 0);
    run("s100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1,
        32'hFFFF_FFF2, 32'd2, 33, 0);
    run("uzero", 32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 33, 0);
    run("ubig", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0,
        32'd1, 32'h7FFF_FFFE, 33, 0);
    run("umin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
        32'd0, 32'h8000_0000, 33, 0);
    run("udz", 32'h0000_1234, 32'd0, 1'b0,
        32'hFFFF_FFFF, 32'h0000_1234, SLAT, 0);
    run("sdz", 32'h0000_1234, 32'd0, 1'b1,
        32'hFFFF_FFFF, 32'h0000_1234, SLAT, 0);
    run("sdzneg", 32'hFFFF_FFF0, 32'd0, 1'b1,
        32'hFFFF_FFFF, 32'hFFFF_FFF0, SLAT, 0);
    run("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
        32'h8000_0000, 32'd0, SLAT, 0);
    run("busyprot", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 10);

    i_op_a = 32'd1000; i_op_b = 32'd3; i_signed = 1'b0; i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (14) @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("midrst busy", {31'b0, o_busy}, 32'd0);
    check("midrst valid", {31'b0, o_valid}, 32'd0);
    check("midrst quot", o_quot, 32'd0);
    check("midrst rem", o_rem, 32'd0);
    nv = 0;
    repeat (3) begin
      @(negedge i_clk);
      if (o_valid) nv++;
    end
    i_rst_n = 1'b1;
    repeat (40) begin
      @(negedge i_clk);
      if (o_valid) nv++;
    end
    check("midrst novalid", 32'(nv), 32'd0);
    run("post-rst", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 33, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
